pg_port_ctrl: RTL and testbench
===============================

Name: pg_port_ctrl

Overview:
- Per-router power-gating controller for the four mesh output ports [S, N, W, E].
- Sequences the load-tracking epochs: issues the periodic pgEnable pulse and samples the per-port and router load results one cycle later.
- Decides which ports to drain, gate, or wake, and drives portStatus back to the load tracker and the router datapath.

Parameters:
- EPOCH_LEN, 64, cycles per load-tracking epoch; legal range ≥4.
- PORT_LOAD_W, 6, width of each port-load field; equals PG_PORT_LOAD_SIZE.
- ROUTER_LOAD_W, 8, width of routerLoad; equals PG_ROUTER_LOAD_SIZE.
- STAT_W, 2, width of each port-status field; equals PORT_STAT_SIZE.
- SLEEP_TH, 2, an ACTIVE port is a sleep candidate if its portLoad < SLEEP_TH.
- WAKE_TH, 8, an INACTIVE port wakes if its portLoad ≥ WAKE_TH.
- ROUTER_SLEEP_TH, 16, no port may start draining unless routerLoad < ROUTER_SLEEP_TH.
- WAKE_LAT, 4, cycles spent in WAKEUP before a port returns to ACTIVE; legal range ≥1.
- MIN_ACTIVE, 2, minimum number of ports in ACTIVE or WAKEUP at all times.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-low reset.
- pgCtrlEn, input, 1, global enable for gating decisions.
- portLoad, input, 4*PORT_LOAD_W, per-port utilization [S, N, W, E]; valid the cycle after pgEnable.
- routerLoad, input, ROUTER_LOAD_W, sum of port loads; same timing as portLoad.
- portBusy, input, 4, port i holds an in-flight flit.
- forceWake, input, 4, immediate wake request per port (e.g. upstream credit stall).
- pgEnable, output, 1, one-cycle epoch-close pulse to the load tracker.
- portStatus, output, 4*STAT_W, per-port state [S, N, W, E].
- powerGate, output, 4, 1 = port power switched off.

Behaviour:
- Status encoding: ACTIVE = 0, INACTIVE = 1, WAKEUP = 2, DRAIN = 3.
- Reset (reset == 0 at a clk edge) has top priority and applies from any state, including mid-DRAIN or mid-WAKEUP:
  - epoch counter = 0, pgEnable = 0, decision strobe = 0;
  - all ports ACTIVE, powerGate = 4'b0000;
  - wake counters and hysteresis flags cleared.
- Epoch counter:
  - Counts 0..EPOCH_LEN-1 and wraps.
  - pgEnable is registered and equals 1 exactly in the cycle the counter equals EPOCH_LEN-1.
  - While pgCtrlEn == 0: counter held at 0, pgEnable = 0.
- Decision strobe = pgEnable delayed by one cycle. portLoad and routerLoad are sampled only on the strobe and ignored at all other times.
- Per-port FSM, with transitions taking effect on the clock edge ending the strobe cycle unless stated otherwise:
  - ACTIVE → DRAIN, at the strobe, when all hold: pgCtrlEn = 1; load < SLEEP_TH; routerLoad < ROUTER_SLEEP_TH; forceWake[i] = 0; the MIN_ACTIVE rule still holds after the move.
    - Candidates are granted in index order 0 (E), 1 (W), 2 (N), 3 (S).
    - Each grant decrements the count of ports in ACTIVE or WAKEUP; a candidate is rejected if the count would fall below MIN_ACTIVE.
  - DRAIN → INACTIVE on the first cycle with portBusy[i] == 0; powerGate[i] rises in that same register update.
  - DRAIN → ACTIVE if forceWake[i] == 1 or pgCtrlEn == 0. This aborts the drain and takes priority over DRAIN → INACTIVE.
  - INACTIVE → WAKEUP, any cycle, if forceWake[i] == 1 or pgCtrlEn == 0. Also at the strobe if load ≥ WAKE_TH. powerGate[i] falls on entry to WAKEUP.
  - WAKEUP → ACTIVE after exactly WAKE_LAT cycles in WAKEUP; the wake counter loads WAKE_LAT-1 on entry.
- Arithmetic:
  - Threshold compares are unsigned, at full input width.
  - Thresholds whose value does not fit the field width saturate to the field maximum.
- A port is never in DRAIN and WAKEUP in the same cycle. A port in WAKEUP ignores the strobe.

Optional Feature:
- Macro: PG_HYSTERESIS_EN.
- Defined: each port keeps a 1-bit lowLoad flag.
  - At the strobe, an ACTIVE port with load < SLEEP_TH sets the flag. Any other ACTIVE-port strobe result clears it.
  - ACTIVE → DRAIN also requires the flag to be already set, i.e. two consecutive low epochs.
  - The flag clears on any state change and on reset.
- Undefined: one low epoch suffices; no flag registers exist.

Test Plan:
- Reset behaviour: hold reset = 0 for 3 cycles, then release with pgCtrlEn = 1 → portStatus = 0, powerGate = 0; pgEnable first pulses at cycle 63 after release, then every 64 cycles.
- Drain and gate E: drive portLoad = {10, 10, 10, 0}, routerLoad = 30 → no sleep (router threshold). Then routerLoad = 12, port E load 0 → E enters DRAIN at the strobe. With portBusy[0] = 1 for 3 more cycles, E holds DRAIN; it reaches INACTIVE and powerGate = 4'b0001 one cycle after portBusy[0] falls.
- MIN_ACTIVE limit: all port loads 0, routerLoad 0 → only E and W drain; N and S stay ACTIVE.
- Threshold wake: E INACTIVE, strobe with E load = 8 → E to WAKEUP and powerGate[0] = 0 at the same edge; E returns to ACTIVE exactly 4 cycles later. A strobe with E load = 7 leaves E INACTIVE.
- forceWake priority: forceWake[1] pulses while W is in DRAIN → W returns to ACTIVE with no INACTIVE cycle. Pulsed while W is INACTIVE → W enters WAKEUP immediately, not waiting for the strobe.
- Global disable and hysteresis: dropping pgCtrlEn with ports in DRAIN and INACTIVE → those ports go to ACTIVE and WAKEUP respectively, pgEnable stays 0, and the counter holds at 0. With PG_HYSTERESIS_EN, port E load 0 for one epoch → no drain; for two consecutive epochs → drain at the second strobe.

Source files
------------

// File: rtl/pg_port_ctrl.sv
// Per-router power-gating controller for the four mesh output ports.
// Optional two-epoch sleep hysteresis: define PG_HYSTERESIS_EN.
module pg_port_ctrl #(
  parameter int EPOCH_LEN       = 64,
  parameter int PORT_LOAD_W     = 6,
  parameter int ROUTER_LOAD_W   = 8,
  parameter int STAT_W          = 2,
  parameter int SLEEP_TH        = 2,
  parameter int WAKE_TH         = 8,
  parameter int ROUTER_SLEEP_TH = 16,
  parameter int WAKE_LAT        = 4,
  parameter int MIN_ACTIVE      = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pgCtrlEn,
  input  logic [4*PORT_LOAD_W-1:0] portLoad,
  input  logic [ROUTER_LOAD_W-1:0] routerLoad,
  input  logic [3:0]               portBusy,
  input  logic [3:0]               forceWake,
  output logic                     pgEnable,
  output logic [4*STAT_W-1:0]      portStatus,
  output logic [3:0]               powerGate
);

  typedef enum logic [1:0] {
    ACTIVE   = 2'd0,
    INACTIVE = 2'd1,
    WAKEUP   = 2'd2,
    DRAIN    = 2'd3
  } stat_e;

  localparam int CW  = $clog2(EPOCH_LEN);
  localparam int WCW = $clog2(WAKE_LAT + 1);

  localparam int PL_MAX = (1 << PORT_LOAD_W) - 1;
  localparam int RL_MAX = (1 << ROUTER_LOAD_W) - 1;

  // Thresholds too wide for their field saturate to the field maximum
  localparam logic [PORT_LOAD_W-1:0] SLEEP_T =
    PORT_LOAD_W'((SLEEP_TH > PL_MAX) ? PL_MAX : SLEEP_TH);
  localparam logic [PORT_LOAD_W-1:0] WAKE_T =
    PORT_LOAD_W'((WAKE_TH > PL_MAX) ? PL_MAX : WAKE_TH);
  localparam logic [ROUTER_LOAD_W-1:0] RSLEEP_T =
    ROUTER_LOAD_W'((ROUTER_SLEEP_TH > RL_MAX) ?
                   RL_MAX : ROUTER_SLEEP_TH);

  logic [CW-1:0]  cnt;
  logic           strobe;
  stat_e          st [4];
  logic [WCW-1:0] wcnt [4];

  logic [3:0] low;
  logic [3:0] hot;
  logic [3:0] cand;
  logic [3:0] grant;
  logic [3:0] armed;
  logic       rlow;
  int         avail;

  always_comb begin
    rlow  = routerLoad < RSLEEP_T;
    avail = 0;
    low   = '0;
    hot   = '0;
    cand  = '0;
    grant = '0;
    for (int i = 0; i < 4; i++) begin
      low[i] = portLoad[i*PORT_LOAD_W +: PORT_LOAD_W] < SLEEP_T;
      hot[i] = portLoad[i*PORT_LOAD_W +: PORT_LOAD_W] >= WAKE_T;
      cand[i] = strobe && pgCtrlEn && (st[i] == ACTIVE) &&
                low[i] && rlow && !forceWake[i] && armed[i];
      if (st[i] == ACTIVE || st[i] == WAKEUP)
        avail = avail + 1;
    end
    // Lowest index wins while the awake count stays at or above the floor
    for (int i = 0; i < 4; i++) begin
      if (cand[i] && avail > MIN_ACTIVE) begin
        grant[i] = 1'b1;
        avail    = avail - 1;
      end
    end
  end

`ifdef PG_HYSTERESIS_EN
  logic [3:0] lowflag;

  assign armed = lowflag;

  always_ff @(posedge clk) begin
    if (!reset) begin
      lowflag <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (st[i] != ACTIVE || grant[i])
          lowflag[i] <= 1'b0;
        else if (strobe)
          lowflag[i] <= low[i];
      end
    end
  end
`else
  assign armed = 4'hF;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= '0;
      pgEnable  <= 1'b0;
      strobe    <= 1'b0;
      powerGate <= '0;
      for (int i = 0; i < 4; i++) begin
        st[i]   <= ACTIVE;
        wcnt[i] <= '0;
      end
    end else begin
      if (!pgCtrlEn) begin
        cnt      <= '0;
        pgEnable <= 1'b0;
      end else begin
        cnt      <= (cnt == CW'(EPOCH_LEN - 1)) ? '0 : cnt + 1'b1;
        pgEnable <= (cnt == CW'(EPOCH_LEN - 2));
      end
      strobe <= pgEnable;

      for (int i = 0; i < 4; i++) begin
        unique case (st[i])
          ACTIVE: begin
            if (grant[i])
              st[i] <= DRAIN;
          end
          DRAIN: begin
            if (forceWake[i] || !pgCtrlEn) begin
              st[i] <= ACTIVE;
            end else if (!portBusy[i]) begin
              st[i]        <= INACTIVE;
              powerGate[i] <= 1'b1;
            end
          end
          INACTIVE: begin
            if (forceWake[i] || !pgCtrlEn ||
                (strobe && hot[i])) begin
              st[i]        <= WAKEUP;
              powerGate[i] <= 1'b0;
              wcnt[i]      <= WCW'(WAKE_LAT - 1);
            end
          end
          WAKEUP: begin
            if (wcnt[i] == '0)
              st[i] <= ACTIVE;
            else
              wcnt[i] <= wcnt[i] - 1'b1;
          end
          default: st[i] <= ACTIVE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_stat
    assign portStatus[g*STAT_W +: STAT_W] = STAT_W'(st[g]);
  end

endmodule

// File: tb/tb_pg_port_ctrl.sv
// Self-checking bench for pg_port_ctrl: epoch-level model plus
// directed scenarios with literal expectations.
module tb_pg_port_ctrl;

  localparam int EPOCH = 64;
  localparam int WLAT  = 4;
  localparam int ACT = 0, INA = 1, WK = 2, DRN = 3;

  logic        clk;
  logic        reset;
  logic        pgCtrlEn;
  logic [23:0] portLoad;
  logic [7:0]  routerLoad;
  logic [3:0]  portBusy;
  logic [3:0]  forceWake;
  logic        pgEnable;
  logic [7:0]  portStatus;
  logic [3:0]  powerGate;

  pg_port_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .pgCtrlEn  (pgCtrlEn),
    .portLoad  (portLoad),
    .routerLoad(routerLoad),
    .portBusy  (portBusy),
    .forceWake (forceWake),
    .pgEnable  (pgEnable),
    .portStatus(portStatus),
    .powerGate (powerGate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  function automatic void check(string name,
                                logic [31:0] act,
                                logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Model: epoch position as a running count, ports as a list of
  // states with wake-entry timestamps.
  int unsigned edge_n = 0;
  int  m_run = 0;
  bit  m_strobe = 0;
  int  m_st [4];
  bit  m_gate [4];
  int  m_wk [4];
  bit  m_flag [4];

  always @(posedge clk) begin
    int  awake;
    int  ld;
    bit  pg_now;
    bit  lowl;
    bit  arm;
    edge_n++;
    if (!reset) begin
      m_run = 0;
      m_strobe = 0;
      for (int i = 0; i < 4; i++) begin
        m_st[i] = ACT;
        m_gate[i] = 0;
        m_wk[i] = 0;
        m_flag[i] = 0;
      end
    end else begin
      pg_now = (m_run % EPOCH) == EPOCH - 1;
      awake = 0;
      for (int i = 0; i < 4; i++)
        if (m_st[i] == ACT || m_st[i] == WK) awake++;
      for (int i = 0; i < 4; i++) begin
        ld = int'(portLoad[i*6 +: 6]);
        lowl = ld < 2;
`ifdef PG_HYSTERESIS_EN
        arm = m_flag[i];
`else
        arm = 1;
`endif
        case (m_st[i])
          ACT: begin
            if (m_strobe && pgCtrlEn && lowl &&
                int'(routerLoad) < 16 && !forceWake[i] &&
                arm && awake - 1 >= 2) begin
              m_st[i] = DRN;
              m_flag[i] = 0;
              awake--;
            end else if (m_strobe) begin
              m_flag[i] = lowl;
            end
          end
          DRN: begin
            if (forceWake[i] || !pgCtrlEn) begin
              m_st[i] = ACT;
            end else if (!portBusy[i]) begin
              m_st[i] = INA;
              m_gate[i] = 1;
            end
          end
          INA: begin
            if (forceWake[i] || !pgCtrlEn ||
                (m_strobe && ld >= 8)) begin
              m_st[i] = WK;
              m_gate[i] = 0;
              m_wk[i] = int'(edge_n);
            end
          end
          default: begin
            if (int'(edge_n) - m_wk[i] == WLAT) m_st[i] = ACT;
          end
        endcase
      end
      m_strobe = pg_now;
      m_run = pgCtrlEn ? m_run + 1 : 0;
    end
  end

  always @(negedge clk) begin
    logic [7:0] es;
    logic [3:0] eg;
    if (chk_on) begin
      for (int i = 0; i < 4; i++) begin
        es[i*2 +: 2] = 2'(m_st[i]);
        eg[i] = m_gate[i];
      end
      check("model_pgEnable", 32'(pgEnable),
            32'((m_run % EPOCH) == EPOCH - 1));
      check("model_portStatus", 32'(portStatus), 32'(es));
      check("model_powerGate", 32'(powerGate), 32'(eg));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  // Returns at the negedge just after the next strobe edge
  task automatic wait_strobe();
    int n = 0;
    @(negedge clk);
    while (!m_strobe && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!m_strobe) begin
      checks++;
      errors++;
      $display("FAIL strobe_timeout: got none expected strobe");
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int second;
    int pulses;
    reset      = 1'b0;
    pgCtrlEn   = 1'b1;
    portLoad   = {6'd10, 6'd10, 6'd10, 6'd10};
    routerLoad = 8'd40;
    portBusy   = 4'b0000;
    forceWake  = 4'b0000;

    // Reset and epoch cadence
    do_reset();
    chk_on = 1;
    check("rst_status", 32'(portStatus), 32'h00);
    check("rst_gate", 32'(powerGate), 32'h0);
    check("rst_pgEnable", 32'(pgEnable), 32'h0);
    first = -1;
    second = -1;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk);
      if (pgEnable && first < 0) first = k;
      else if (pgEnable && second < 0) second = k;
    end
    check("first_pulse", 32'(first), 32'd63);
    check("second_pulse", 32'(second), 32'd127);

    // Router threshold blocks sleep, then E drains and gates
    portLoad   = {6'd10, 6'd10, 6'd10, 6'd0};
    routerLoad = 8'd30;
    portBusy   = 4'b0001;
    wait_strobe();
    check("router_block", 32'(portStatus), 32'h00);
    routerLoad = 8'd12;
    wait_strobe();
    check("e_drain", 32'(portStatus), 32'h03);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("e_hold_drain", 32'(portStatus), 32'h03);
    end
    portBusy = 4'b0000;
    @(negedge clk);
    check("e_inactive", 32'(portStatus), 32'h01);
    check("e_gate", 32'(powerGate), 32'h1);

    // MIN_ACTIVE floor
    do_reset();
    portLoad   = '0;
    routerLoad = 8'd0;
    wait_strobe();
    check("min_active_drain", 32'(portStatus), 32'h0F);
    @(negedge clk);
    check("min_active_gated", 32'(portStatus), 32'h05);
    check("min_active_gate", 32'(powerGate), 32'h3);

    // Threshold wake: 7 keeps E asleep, 8 wakes it
    portLoad = {6'd0, 6'd0, 6'd0, 6'd7};
    wait_strobe();
    check("load7_stays", 32'(portStatus), 32'h05);
    portLoad = {6'd0, 6'd0, 6'd0, 6'd8};
    wait_strobe();
    check("load8_wakeup", 32'(portStatus), 32'h06);
    check("load8_ungate", 32'(powerGate), 32'h2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("wakeup_hold", 32'(portStatus), 32'h06);
    end
    @(negedge clk);
    check("wakeup_done", 32'(portStatus), 32'h04);

    // forceWake aborts a drain and wakes a gated port at once
    do_reset();
    portLoad   = {6'd10, 6'd10, 6'd0, 6'd10};
    routerLoad = 8'd12;
    portBusy   = 4'b0010;
    wait_strobe();
    check("w_drain", 32'(portStatus), 32'h0C);
    forceWake = 4'b0010;
    @(negedge clk);
    forceWake = 4'b0000;
    check("fw_abort", 32'(portStatus), 32'h00);
    check("fw_abort_gate", 32'(powerGate), 32'h0);
    wait_strobe();
    check("w_drain2", 32'(portStatus), 32'h0C);
    portBusy = 4'b0000;
    @(negedge clk);
    check("w_inactive", 32'(portStatus), 32'h04);
    check("w_gate", 32'(powerGate), 32'h2);
    forceWake = 4'b0010;
    @(negedge clk);
    forceWake = 4'b0000;
    check("fw_wakeup", 32'(portStatus), 32'h08);
    check("fw_ungate", 32'(powerGate), 32'h0);

    // Global disable
    do_reset();
    portLoad   = {6'd10, 6'd10, 6'd0, 6'd0};
    routerLoad = 8'd0;
    portBusy   = 4'b0010;
    wait_strobe();
    check("dis_both_drain", 32'(portStatus), 32'h0F);
    @(negedge clk);
    check("dis_pre", 32'(portStatus), 32'h0D);
    check("dis_pre_gate", 32'(powerGate), 32'h1);
    pgCtrlEn = 1'b0;
    @(negedge clk);
    check("dis_status", 32'(portStatus), 32'h02);
    check("dis_gate", 32'(powerGate), 32'h0);
    pulses = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (pgEnable) pulses++;
    end
    check("dis_no_pulse", 32'(pulses), 32'd0);
    pgCtrlEn = 1'b1;
    first = -1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (pgEnable && first < 0) first = k;
    end
    check("reen_pulse", 32'(first), 32'd63);

`ifdef PG_HYSTERESIS_EN
    do_reset();
    portLoad   = {6'd10, 6'd10, 6'd10, 6'd0};
    routerLoad = 8'd0;
    portBusy   = 4'b0001;
    wait_strobe();
    check("hyst_one_epoch", 32'(portStatus), 32'h00);
    wait_strobe();
    check("hyst_two_epochs", 32'(portStatus), 32'h03);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
